// File: rtl/uart_bridge_pkg.sv
// Shared constants for the UART-to-register bridge: packet bytes, reply bytes
// and the responder state encoding.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_GET_ADDR = 3'd1;
  localparam state_t ST_GET_DATA = 3'd2;
  localparam state_t ST_BUS_WR   = 3'd3;
  localparam state_t ST_BUS_RD   = 3'd4;
  localparam state_t ST_RD_CAP   = 3'd5;
  localparam state_t ST_SEND     = 3'd6;

  // States in which the bridge is willing to pop an RX byte.
  function automatic logic st_accepts_rx(input state_t st);
    return (st == ST_IDLE) || (st == ST_GET_ADDR) || (st == ST_GET_DATA);
  endfunction

  // States in which a partial packet is pending and the idle timer runs.
  function automatic logic st_in_packet(input state_t st);
    return (st == ST_GET_ADDR) || (st == ST_GET_DATA);
  endfunction

endpackage

// File: rtl/uart_reg_bridge.sv
// Serial command responder: decodes W/R packets from the UART RX byte stream,
// drives one local-bus strobe per packet and answers with a single TX byte.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 8680
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            uart_r_data,
  input  logic                  uart_r_ready,
  output logic                  uart_r_valid,
  output logic [7:0]            uart_w_data,
  output logic                  uart_w_valid,
  input  logic                  uart_w_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [7:0]            bus_rdata,
  output logic                  timeout_pulse,
  output logic                  badcmd_pulse
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            reply_q, reply_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  r_valid_q, r_valid_d;
  logic                  w_valid_q, w_valid_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  to_q, to_d;
  logic                  bad_q, bad_d;

  logic pop;
  logic push;
  logic timeout_hit;

  assign pop  = r_valid_q & uart_r_ready;
  assign push = w_valid_q & uart_w_ready;

  // A pop in the expiry cycle keeps the packet alive.
  assign timeout_hit = st_in_packet(state_q) && (cnt_q == CNT_LAST) && !pop;

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    reply_d = reply_q;
    to_d    = 1'b0;
    bad_d   = 1'b0;

    if (pop || !st_in_packet(state_q)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if (uart_r_data == CMD_WRITE) begin
            state_d = ST_GET_ADDR;
            is_wr_d = 1'b1;
          end else if (uart_r_data == CMD_READ) begin
            state_d = ST_GET_ADDR;
            is_wr_d = 1'b0;
          end else begin
            state_d = ST_SEND;
            reply_d = RSP_ERR;
            bad_d   = 1'b1;
          end
        end
      end
      ST_GET_ADDR: begin
        if (pop) begin
          addr_d  = uart_r_data[ADDR_WIDTH-1:0];
          state_d = is_wr_q ? ST_GET_DATA : ST_BUS_RD;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          to_d    = 1'b1;
        end
      end
      ST_GET_DATA: begin
        if (pop) begin
          wdata_d = uart_r_data;
          state_d = ST_BUS_WR;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          to_d    = 1'b1;
        end
      end
      ST_BUS_WR: begin
        reply_d = RSP_ACK;
        state_d = ST_SEND;
      end
      ST_BUS_RD: begin
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        reply_d = bus_rdata;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (push) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake and strobe outputs are registered decodes of the next state.
    r_valid_d = st_accepts_rx(state_d);
    w_valid_d = (state_d == ST_SEND);
    we_d      = (state_d == ST_BUS_WR);
    re_d      = (state_d == ST_BUS_RD);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      reply_q   <= '0;
      cnt_q     <= '0;
      r_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      to_q      <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      reply_q   <= reply_d;
      cnt_q     <= cnt_d;
      r_valid_q <= r_valid_d;
      w_valid_q <= w_valid_d;
      we_q      <= we_d;
      re_q      <= re_d;
      to_q      <= to_d;
      bad_q     <= bad_d;
    end
  end

  assign uart_r_valid  = r_valid_q;
  assign uart_w_valid  = w_valid_q;
  assign uart_w_data   = reply_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_we        = we_q;
  assign bus_re        = re_q;
  assign timeout_pulse = to_q;
  assign badcmd_pulse  = bad_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: a packet table plus hand-written
// timeout, backpressure and mid-packet reset sequences.
module tb_uart_reg_bridge;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] uart_r_data;
  logic       uart_r_ready;
  logic       uart_r_valid;
  logic [7:0] uart_w_data;
  logic       uart_w_valid;
  logic       uart_w_ready;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata = 8'hEE;
  logic       timeout_pulse;
  logic       badcmd_pulse;

  uart_reg_bridge #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .uart_r_data  (uart_r_data),
    .uart_r_ready (uart_r_ready),
    .uart_r_valid (uart_r_valid),
    .uart_w_data  (uart_w_data),
    .uart_w_valid (uart_w_valid),
    .uart_w_ready (uart_w_ready),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_we       (bus_we),
    .bus_re       (bus_re),
    .bus_rdata    (bus_rdata),
    .timeout_pulse(timeout_pulse),
    .badcmd_pulse (badcmd_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  int pop_cnt = 0, last_pop_cyc = 0;
  int we_cnt = 0, re_cnt = 0, both_cnt = 0;
  int push_cnt = 0, bad_cnt = 0, to_cnt = 0, to_cyc = 0;
  int wv_start = 0, stab_err = 0, rv_err = 0;
  logic       wv_prev = 1'b0;
  logic [7:0] wd_prev = 8'h00;
  logic       re_flag = 1'b0;
  logic [7:0] rd_value = 8'h00;

  always @(negedge clk) begin
    if (uart_r_valid && uart_r_ready) begin
      pop_cnt      <= pop_cnt + 1;
      last_pop_cyc <= cyc;
    end
    if (bus_we) we_cnt <= we_cnt + 1;
    if (bus_re) re_cnt <= re_cnt + 1;
    if (bus_we && bus_re) both_cnt <= both_cnt + 1;
    if (uart_w_valid && uart_w_ready) push_cnt <= push_cnt + 1;
    if (badcmd_pulse) bad_cnt <= bad_cnt + 1;
    if (timeout_pulse) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
    if (uart_w_valid && !wv_prev) wv_start <= cyc;
    if (uart_w_valid && wv_prev && (uart_w_data != wd_prev)) stab_err <= stab_err + 1;
    if (uart_w_valid && uart_r_valid) rv_err <= rv_err + 1;
    wv_prev <= uart_w_valid && !uart_w_ready;
    wd_prev <= uart_w_data;
    re_flag <= bus_re;
  end

  // Read data is only meaningful in the cycle after bus_re; garbage otherwise.
  always begin
    @(posedge clk);
    #2;
    bus_rdata = re_flag ? rd_value : 8'hEE;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    uart_r_data  = b;
    uart_r_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (uart_r_valid) done = 1'b1;
      @(posedge clk);
      #1;
    end
    uart_r_ready = 1'b0;
    chk("pop_wait", 32'(done), 32'd1);
  endtask

  task automatic wait_push(input int p0);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #1;
      if (push_cnt > p0) done = 1'b1;
    end
    chk("push_wait", 32'(done), 32'd1);
    tick(1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {uart_r_valid, uart_w_valid, uart_w_data, bus_addr, bus_wdata,
               bus_we, bus_re, timeout_pulse, badcmd_pulse}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         nbytes;
    logic [7:0] rdata;
    logic [7:0] exp_reply;
    int         exp_we, exp_re, exp_bad;
    logic [7:0] exp_addr, exp_wdata;
    int         exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int we0, re0, p0, b0, t0;
    we0 = we_cnt; re0 = re_cnt; p0 = push_cnt; b0 = bad_cnt; t0 = to_cnt;
    rd_value = v.rdata;
    send_byte(v.b0);
    if (v.nbytes > 1) send_byte(v.b1);
    if (v.nbytes > 2) send_byte(v.b2);
    wait_push(p0);
    chk({tag, "_reply"}, 32'(uart_w_data), 32'(v.exp_reply));
    chk({tag, "_we"},    32'(we_cnt - we0), 32'(v.exp_we));
    chk({tag, "_re"},    32'(re_cnt - re0), 32'(v.exp_re));
    chk({tag, "_bad"},   32'(bad_cnt - b0), 32'(v.exp_bad));
    chk({tag, "_to"},    32'(to_cnt - t0),  32'd0);
    chk({tag, "_addr"},  32'(bus_addr),  32'(v.exp_addr));
    chk({tag, "_wdata"}, 32'(bus_wdata), 32'(v.exp_wdata));
    chk({tag, "_lat"},   32'(wv_start - last_pop_cyc), 32'(v.exp_lat));
    $display("%s: cmd %02h reply %02h addr %02h wdata %02h", tag, v.b0, uart_w_data, bus_addr, bus_wdata);
  endtask

  vec_t vecs[8];

  initial begin
    int p0, we0, t0, pop_n;

    vecs[0] = '{8'h57, 8'h10, 8'hA5, 3, 8'h00, 8'h4B, 1, 0, 0, 8'h10, 8'hA5, 2};
    vecs[1] = '{8'h52, 8'h22, 8'h00, 2, 8'h3C, 8'h3C, 0, 1, 0, 8'h22, 8'hA5, 3};
    vecs[2] = '{8'h41, 8'h00, 8'h00, 1, 8'h00, 8'h3F, 0, 0, 1, 8'h22, 8'hA5, 1};
    vecs[3] = '{8'h52, 8'h05, 8'h00, 2, 8'h99, 8'h99, 0, 1, 0, 8'h05, 8'hA5, 3};
    vecs[4] = '{8'h57, 8'hFF, 8'h00, 3, 8'h00, 8'h4B, 1, 0, 0, 8'hFF, 8'h00, 2};
    vecs[5] = '{8'h52, 8'hFF, 8'h00, 2, 8'h00, 8'h00, 0, 1, 0, 8'hFF, 8'h00, 3};
    vecs[6] = '{8'h52, 8'h57, 8'h00, 2, 8'h5A, 8'h5A, 0, 1, 0, 8'h57, 8'h00, 3};
    vecs[7] = '{8'h4B, 8'h00, 8'h00, 1, 8'h00, 8'h3F, 0, 0, 1, 8'h57, 8'h00, 1};

    rst_n        = 1'b0;
    uart_r_data  = 8'h00;
    uart_r_ready = 1'b0;
    uart_w_ready = 1'b1;

    tick(3);
    check_reset_outputs("reset_outputs");
    rst_n = 1'b1;
    tick(1);
    chk("r_valid_after_reset", 32'(uart_r_valid), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Byte arriving exactly in the expiry cycle still completes the packet.
    we0 = we_cnt; t0 = to_cnt; p0 = push_cnt;
    send_byte(8'h57);
    send_byte(8'h10);
    pop_n = last_pop_cyc;
    tick(T - 1);
    send_byte(8'hA5);
    wait_push(p0);
    chk("edge_pop_gap", 32'(last_pop_cyc - pop_n), 32'(T));
    chk("edge_no_timeout", 32'(to_cnt - t0), 32'd0);
    chk("edge_we", 32'(we_cnt - we0), 32'd1);
    chk("edge_reply", 32'(uart_w_data), 32'h4B);
    $display("edge-timing write: reply %02h wdata %02h", uart_w_data, bus_wdata);

    // Partial write abandoned: timeout, no strobe, no reply.
    we0 = we_cnt; t0 = to_cnt; p0 = push_cnt;
    send_byte(8'h57);
    send_byte(8'h20);
    pop_n = last_pop_cyc;
    tick(T + 4);
    chk("to_pulse", 32'(to_cnt - t0), 32'd1);
    chk("to_cycle", 32'(to_cyc - pop_n), 32'(T + 1));
    chk("to_no_we", 32'(we_cnt - we0), 32'd0);
    chk("to_no_push", 32'(push_cnt - p0), 32'd0);
    chk("to_r_valid", 32'(uart_r_valid), 32'd1);
    $display("timeout: pulses %0d", to_cnt - t0);
    run_vec('{8'h52, 8'h10, 8'h00, 2, 8'h77, 8'h77, 0, 1, 0, 8'h10, 8'hA5, 3}, "read_after_to");

    // Reply held back by TX backpressure.
    uart_w_ready = 1'b0;
    p0 = push_cnt;
    rd_value = 8'hC3;
    send_byte(8'h52);
    send_byte(8'h33);
    tick(55);
    chk("bp_w_valid", 32'(uart_w_valid), 32'd1);
    chk("bp_w_data", 32'(uart_w_data), 32'hC3);
    chk("bp_r_valid", 32'(uart_r_valid), 32'd0);
    chk("bp_no_push", 32'(push_cnt - p0), 32'd0);
    uart_w_ready = 1'b1;
    wait_push(p0);
    tick(5);
    chk("bp_one_push", 32'(push_cnt - p0), 32'd1);
    chk("bp_stable", 32'(stab_err), 32'd0);
    chk("bp_rx_blocked", 32'(rv_err), 32'd0);
    $display("backpressure read: reply %02h pushes %0d", uart_w_data, push_cnt - p0);

    // Reset while waiting for the data byte.
    we0 = we_cnt; p0 = push_cnt;
    send_byte(8'h57);
    send_byte(8'h01);
    rst_n = 1'b0;
    tick(2);
    check_reset_outputs("rst_getdata_outputs");
    rst_n = 1'b1;
    tick(10);
    chk("rst_getdata_no_we", 32'(we_cnt - we0), 32'd0);
    chk("rst_getdata_no_push", 32'(push_cnt - p0), 32'd0);
    chk("rst_getdata_r_valid", 32'(uart_r_valid), 32'd1);
    $display("reset in GET_DATA: bus_addr %02h", bus_addr);

    // Reset while a reply is pending.
    uart_w_ready = 1'b0;
    p0 = push_cnt;
    send_byte(8'h41);
    tick(3);
    chk("rst_send_pending", 32'(uart_w_valid), 32'd1);
    rst_n = 1'b0;
    tick(2);
    check_reset_outputs("rst_send_outputs");
    rst_n = 1'b1;
    uart_w_ready = 1'b1;
    tick(10);
    chk("rst_send_no_push", 32'(push_cnt - p0), 32'd0);
    $display("reset in SEND: pushes %0d", push_cnt - p0);
    run_vec('{8'h57, 8'h01, 8'hFF, 3, 8'h00, 8'h4B, 1, 0, 0, 8'h01, 8'hFF, 2}, "write_after_rst");

    chk("strobe_overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
